decrypt_rx_frontend: RTL and testbench
======================================

# decrypt_rx_frontend

UART byte receiver and framer that sits directly upstream of the combinational `decrypt` stage. It deserialises 8N1 serial data from the FPGA pin and separates key-load commands from ciphertext bytes. It drives the `decrypt` `key` input from a held key register and its `inp` input from a valid/ready-qualified ciphertext register.

## Interface
- `CLKS_PER_BIT`, default 104: clock cycles per UART bit (12 MHz / 115200); must be ≥ 8.
- `KEY_CMD`, default 8'hA5: prefix byte announcing a key load.
- `KEY_RESET`, default 8'h3C: key value after reset.

Ports:
- `clk`  in  1  single system clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `rx_i`  in  1  asynchronous serial input; idle high.
- `key_o`  out  8  current key; feeds `decrypt.key`.
- `cipher_o`  out  8  ciphertext byte; feeds `decrypt.inp`.
- `cipher_valid_o`  out  1  `cipher_o` holds an unconsumed byte.
- `cipher_ready_i`  in  1  consumer accepts the byte at this edge when valid.
- `frame_err_o`  out  1  one-cycle pulse: bad stop bit (or bad parity, see Configuration).
- `overrun_o`  out  1  one-cycle pulse: a byte was dropped because the holding register was full.

## Operation
- `rx_i` passes through a 2-flop synchroniser before any use.
- Bit FSM states:
  - IDLE → START on a synchronised falling edge.
  - START: wait `CLKS_PER_BIT/2`. If the line is still low → DATA; if high → IDLE (glitch rejected).
  - DATA: sample 8 bits LSB first, each `CLKS_PER_BIT` after the previous sample → STOP.
  - STOP: sample once.
    - High: byte complete → IDLE.
    - Low: pulse `frame_err_o`, discard the byte, wait for the line to go high → IDLE.
- Protocol FSM (byte level), states NORMAL and KEY_PEND:
  - NORMAL, byte == `KEY_CMD` → KEY_PEND, nothing emitted.
  - NORMAL, any other byte → emitted as ciphertext.
  - KEY_PEND, byte == `KEY_CMD` → emit 8'hA5 as ciphertext (escape) → NORMAL.
  - KEY_PEND, any other byte → `key_o` loaded → NORMAL. Key value `KEY_CMD` is therefore not loadable.
  - A frame error returns the protocol FSM to NORMAL.
- Emission:
  - Holding register empty, or being consumed in the same cycle: load `cipher_o` and set `cipher_valid_o`.
  - Otherwise: drop the byte and pulse `overrun_o`; the old byte is retained.
- Handshake:
  - `cipher_o` is stable while `cipher_valid_o` is high.
  - Valid clears on the edge where `cipher_ready_i` is high, unless a new byte loads at the same edge.
- Reset (any time, including mid-frame):
  - Both FSMs return to IDLE/NORMAL.
  - `key_o`=`KEY_RESET`, `cipher_o`=0, `cipher_valid_o`=0, `frame_err_o`=0, `overrun_o`=0.

## Timing
- Bit sampling is centred: the first data sample falls 1.5·`CLKS_PER_BIT` after the detected start edge.
- `cipher_valid_o`, `key_o` update, `frame_err_o` and `overrun_o` all occur on the cycle after the stop-bit sample.
- Latency from the start edge at the pin: 2 + `CLKS_PER_BIT/2` + 9·`CLKS_PER_BIT` + 1 cycles.
- Back-to-back frames are supported: a new start edge is recognised in the cycle after returning to IDLE.
- A `key_o` change does not affect `cipher_valid_o`. A pending ciphertext byte is decrypted with whatever key is current when it is consumed.

## Configuration
- Macro `DECRYPT_RX_PARITY_EN`.
  - Defined: frames are 8E1. The bit FSM adds a PARITY state between DATA and STOP. A parity mismatch pulses `frame_err_o` and the byte is discarded. Latency grows by `CLKS_PER_BIT`.
  - Undefined: 8N1 with no PARITY state.

## Structure
- Shared package `crypt_pkg` holds:
  - default constants for `KEY_CMD` and `KEY_RESET`;
  - the bit-FSM state enum;
  - the protocol-FSM state enum.
- Sub-module `uart_rx_core` contains the synchroniser, bit FSM, baud counter and optional parity. It outputs `byte`, a one-cycle `byte_done` and a one-cycle `err`.
- `decrypt_rx_frontend` contains the protocol FSM, key register and holding register.

## Test plan
All scenarios use `CLKS_PER_BIT`=16; ready is high unless stated.
- Reset release → `key_o`=8'h3C, `cipher_valid_o`=0, no pulses.
- Send 0x86 with ready low for 20 cycles → valid held with `cipher_o`=8'h86; cleared one edge after ready rises.
- Send A5, 5A → `key_o`=8'h5A; no valid. Then send A5, A5 → exactly one valid with `cipher_o`=8'hA5.
- Hold ready low, send 1B then 47 → `cipher_o`=1B retained, one `overrun_o` pulse, 47 never appears.
- Stop bit forced low → one `frame_err_o` pulse, no valid. A 4-cycle low glitch on `rx_i` → no activity. Assert `rst_n` mid-frame → all reset values, and the next clean frame is received correctly.
- With `DECRYPT_RX_PARITY_EN`: send 0x09 with a wrong parity bit → `frame_err_o` pulse, no valid; send 0x09 with correct parity → valid with `cipher_o`=8'h09.

Source files
------------

// File: rtl/crypt_pkg.sv
// Shared constants and FSM state encodings for the decrypt receive path.
// Both the bit-level UART core and the byte-level framer import this package.
package crypt_pkg;

    localparam logic [7:0] KEY_CMD_DEFAULT   = 8'hA5;
    localparam logic [7:0] KEY_RESET_DEFAULT = 8'h3C;

    // BIT_PARITY is only reachable when DECRYPT_RX_PARITY_EN is defined
    typedef enum logic [2:0] {
        BIT_IDLE,
        BIT_START,
        BIT_DATA,
        BIT_PARITY,
        BIT_STOP
    } bit_state_e;

    typedef enum logic {
        PROTO_NORMAL,
        PROTO_KEY_PEND
    } proto_state_e;

endpackage

// File: rtl/decrypt_rx_frontend_if.sv
// Output bundle of the receive frontend: held key, ciphertext valid/ready register and error pulses.
// The frontend drives it through the master modport; the decrypt stage consumes it as slave.
interface decrypt_rx_frontend_if;

    logic [7:0] key_o;
    logic [7:0] cipher_o;
    logic       cipher_valid_o;
    logic       cipher_ready_i;
    logic       frame_err_o;
    logic       overrun_o;

    modport master (
        output key_o,
        output cipher_o,
        output cipher_valid_o,
        output frame_err_o,
        output overrun_o,
        input  cipher_ready_i
    );

    modport slave (
        input  key_o,
        input  cipher_o,
        input  cipher_valid_o,
        input  frame_err_o,
        input  overrun_o,
        output cipher_ready_i
    );

endinterface

// File: rtl/uart_rx_core.sv
// Purpose: 2-flop synchroniser + bit FSM deserialising 8N1 (8E1 with DECRYPT_RX_PARITY_EN) frames.
// Latency: byte_done_o/err_o assert combinationally in the stop-sample cycle, 2+CPB/2+9*CPB after the pin edge.
// Backpressure: none; the serial line cannot be stalled, downstream must absorb every byte_done_o.
module uart_rx_core
    import crypt_pkg::*;
#(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_i,
    output logic [7:0] byte_o,
    output logic       byte_done_o,
    output logic       err_o
);

    localparam int                CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_END = CNT_W'(CLKS_PER_BIT / 2 - 1);

    logic             rx_meta_q;
    logic             rx_sync_q;
    logic             rx_prev_q;

    bit_state_e       state_q,   state_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q,   shift_d;
`ifdef DECRYPT_RX_PARITY_EN
    logic             par_err_q, par_err_d;
`endif

    // Synchroniser resets to the idle level so a reset never fakes a start edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rx_i;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= BIT_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
`ifdef DECRYPT_RX_PARITY_EN
            par_err_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
`ifdef DECRYPT_RX_PARITY_EN
            par_err_q <= par_err_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        byte_done_o = 1'b0;
        err_o       = 1'b0;
`ifdef DECRYPT_RX_PARITY_EN
        par_err_d   = par_err_q;
`endif
        case (state_q)
            // Edge-triggered start: after a bad stop bit the line must rise before a new frame begins
            BIT_IDLE: begin
                cnt_d = '0;
                if (rx_prev_q && !rx_sync_q) begin
                    state_d = BIT_START;
                end
            end
            BIT_START: begin
                if (cnt_q == HALF_END) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    state_d   = rx_sync_q ? BIT_IDLE : BIT_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            BIT_DATA: begin
                if (cnt_q == BIT_END) begin
                    cnt_d     = '0;
                    shift_d   = {rx_sync_q, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
`ifdef DECRYPT_RX_PARITY_EN
                        state_d = BIT_PARITY;
`else
                        state_d = BIT_STOP;
`endif
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`ifdef DECRYPT_RX_PARITY_EN
            BIT_PARITY: begin
                if (cnt_q == BIT_END) begin
                    cnt_d     = '0;
                    par_err_d = rx_sync_q ^ (^shift_q);
                    state_d   = BIT_STOP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`endif
            BIT_STOP: begin
                if (cnt_q == BIT_END) begin
                    cnt_d   = '0;
                    state_d = BIT_IDLE;
`ifdef DECRYPT_RX_PARITY_EN
                    if (rx_sync_q && !par_err_q) begin
`else
                    if (rx_sync_q) begin
`endif
                        byte_done_o = 1'b1;
                    end else begin
                        err_o = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = BIT_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign byte_o = shift_q;

endmodule

// File: rtl/decrypt_rx_frontend.sv
// Purpose: UART framer feeding decrypt: splits KEY_CMD-prefixed key loads from ciphertext (parity via DECRYPT_RX_PARITY_EN).
// Latency: cipher valid, key update and error pulses appear the cycle after the stop-bit sample.
// Backpressure: one-byte holding register; a byte arriving while it is full and not consumed is dropped with overrun_o.
module decrypt_rx_frontend
    import crypt_pkg::*;
#(
    parameter int         CLKS_PER_BIT = 104,
    parameter logic [7:0] KEY_CMD      = KEY_CMD_DEFAULT,
    parameter logic [7:0] KEY_RESET    = KEY_RESET_DEFAULT
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         rx_i,
    decrypt_rx_frontend_if.master        bus
);

    logic [7:0]   rx_byte;
    logic         rx_done;
    logic         rx_err;
    logic         emit;

    proto_state_e proto_q,      proto_d;
    logic [7:0]   key_q,        key_d;
    logic [7:0]   cipher_q,     cipher_d;
    logic         cipher_vld_q, cipher_vld_d;
    logic         frame_err_q,  frame_err_d;
    logic         overrun_q,    overrun_d;

    uart_rx_core #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx_core (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_i        (rx_i),
        .byte_o      (rx_byte),
        .byte_done_o (rx_done),
        .err_o       (rx_err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            proto_q      <= PROTO_NORMAL;
            key_q        <= KEY_RESET;
            cipher_q     <= '0;
            cipher_vld_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            proto_q      <= proto_d;
            key_q        <= key_d;
            cipher_q     <= cipher_d;
            cipher_vld_q <= cipher_vld_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
        end
    end

    always_comb begin
        proto_d      = proto_q;
        key_d        = key_q;
        cipher_d     = cipher_q;
        cipher_vld_d = cipher_vld_q & ~bus.cipher_ready_i;
        frame_err_d  = 1'b0;
        overrun_d    = 1'b0;
        emit         = 1'b0;

        if (rx_err) begin
            frame_err_d = 1'b1;
            proto_d     = PROTO_NORMAL;
        end else if (rx_done) begin
            case (proto_q)
                PROTO_NORMAL: begin
                    if (rx_byte == KEY_CMD) begin
                        proto_d = PROTO_KEY_PEND;
                    end else begin
                        emit = 1'b1;
                    end
                end
                // A doubled command byte is the escape for a literal KEY_CMD ciphertext byte
                PROTO_KEY_PEND: begin
                    proto_d = PROTO_NORMAL;
                    if (rx_byte == KEY_CMD) begin
                        emit = 1'b1;
                    end else begin
                        key_d = rx_byte;
                    end
                end
                default: proto_d = PROTO_NORMAL;
            endcase
        end

        if (emit) begin
            if (!cipher_vld_q || bus.cipher_ready_i) begin
                cipher_d     = rx_byte;
                cipher_vld_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    assign bus.key_o          = key_q;
    assign bus.cipher_o       = cipher_q;
    assign bus.cipher_valid_o = cipher_vld_q;
    assign bus.frame_err_o    = frame_err_q;
    assign bus.overrun_o      = overrun_q;

endmodule

// File: tb/tb_decrypt_rx_frontend.sv
// Directed bench for decrypt_rx_frontend at CLKS_PER_BIT=16; a negedge monitor pops
// expected ciphertext bytes from a scoreboard queue whenever a byte is consumed.
`timescale 1ns/1ps
module tb_decrypt_rx_frontend;

    localparam int CPB = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic rx_i  = 1'b1;

    decrypt_rx_frontend_if bus_if();

    decrypt_rx_frontend #(
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rx_i  (rx_i),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    int         n_chk    = 0;
    int         n_pass   = 0;
    int         ferr_cnt = 0;
    int         ovr_cnt  = 0;
    int         exp_ferr = 0;
    int         exp_ovr  = 0;
    logic [7:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s actual=%0h required=%0h", name, act, req);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic drive_bit(input logic v);
        rx_i = v;
        wait_cyc(CPB);
    endtask

    // Start bit, 8 data bits LSB first, optional even parity, stop bit, then idle
    task automatic send_frame(input logic [7:0] d, input logic stop_v, input logic par_flip);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef DECRYPT_RX_PARITY_EN
        drive_bit((^d) ^ par_flip);
`else
        if (par_flip) $display("note: parity flip ignored in 8N1 build");
`endif
        drive_bit(stop_v);
        rx_i = 1'b1;
        wait_cyc(2 * CPB);
    endtask

    // Scoreboard monitor: a byte is consumed at the next posedge when valid and ready are both high
    always @(negedge clk) begin
        logic [7:0] e;
        if (rst_n) begin
            if (bus_if.frame_err_o) ferr_cnt++;
            if (bus_if.overrun_o)   ovr_cnt++;
            if (bus_if.cipher_valid_o && bus_if.cipher_ready_i) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_cipher actual=%0h required=none", bus_if.cipher_o);
                end else begin
                    e = exp_q.pop_front();
                    chk("cipher_data", 32'(bus_if.cipher_o), 32'(e));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_if.cipher_ready_i = 1'b0;
        rst_n = 1'b0;
        rx_i  = 1'b1;
        wait_cyc(3);
        rst_n = 1'b1;
        wait_cyc(2);

        chk("reset_key",    32'(bus_if.key_o),          32'h3C);
        chk("reset_valid",  32'(bus_if.cipher_valid_o), 32'h0);
        chk("reset_cipher", 32'(bus_if.cipher_o),       32'h0);
        chk("reset_ferr",   32'(bus_if.frame_err_o),    32'h0);
        chk("reset_ovr",    32'(bus_if.overrun_o),      32'h0);

        // Held ciphertext under backpressure
        exp_q.push_back(8'h86);
        send_frame(8'h86, 1'b1, 1'b0);
        wait_cyc(20);
        chk("hold_valid",  32'(bus_if.cipher_valid_o), 32'h1);
        chk("hold_cipher", 32'(bus_if.cipher_o),       32'h86);
        bus_if.cipher_ready_i = 1'b1;
        wait_cyc(1);
        chk("valid_cleared", 32'(bus_if.cipher_valid_o), 32'h0);

        // Key load, then escaped command byte
        send_frame(8'hA5, 1'b1, 1'b0);
        send_frame(8'h5A, 1'b1, 1'b0);
        chk("key_loaded", 32'(bus_if.key_o), 32'h5A);
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1, 1'b0);
        send_frame(8'hA5, 1'b1, 1'b0);
        chk("key_after_escape", 32'(bus_if.key_o), 32'h5A);
        chk("escape_drained",   32'(exp_q.size()), 32'h0);

        // Overrun: second byte dropped, first retained
        bus_if.cipher_ready_i = 1'b0;
        exp_q.push_back(8'h1B);
        send_frame(8'h1B, 1'b1, 1'b0);
        send_frame(8'h47, 1'b1, 1'b0);
        exp_ovr++;
        chk("overrun_count", 32'(ovr_cnt),               32'(exp_ovr));
        chk("overrun_hold",  32'(bus_if.cipher_o),       32'h1B);
        chk("overrun_valid", 32'(bus_if.cipher_valid_o), 32'h1);
        bus_if.cipher_ready_i = 1'b1;
        wait_cyc(2);
        chk("overrun_drained", 32'(exp_q.size()), 32'h0);

        // Bad stop bit
        send_frame(8'h33, 1'b0, 1'b0);
        exp_ferr++;
        chk("frame_err_count", 32'(ferr_cnt),              32'(exp_ferr));
        chk("frame_err_valid", 32'(bus_if.cipher_valid_o), 32'h0);

        // Short glitch is rejected by the mid-start-bit check
        rx_i = 1'b0;
        wait_cyc(4);
        rx_i = 1'b1;
        wait_cyc(12 * CPB);
        chk("glitch_ferr",  32'(ferr_cnt),              32'(exp_ferr));
        chk("glitch_ovr",   32'(ovr_cnt),               32'(exp_ovr));
        chk("glitch_valid", 32'(bus_if.cipher_valid_o), 32'h0);

        // Reset in the middle of a frame
        rx_i = 1'b0;
        wait_cyc(3 * CPB);
        rst_n = 1'b0;
        wait_cyc(2);
        chk("midreset_key",    32'(bus_if.key_o),          32'h3C);
        chk("midreset_valid",  32'(bus_if.cipher_valid_o), 32'h0);
        chk("midreset_cipher", 32'(bus_if.cipher_o),       32'h0);
        chk("midreset_ferr",   32'(bus_if.frame_err_o),    32'h0);
        chk("midreset_ovr",    32'(bus_if.overrun_o),      32'h0);
        rx_i = 1'b1;
        wait_cyc(1);
        rst_n = 1'b1;
        wait_cyc(2 * CPB);
        exp_q.push_back(8'hC3);
        send_frame(8'hC3, 1'b1, 1'b0);
        chk("post_reset_key",     32'(bus_if.key_o),  32'h3C);
        chk("post_reset_drained", 32'(exp_q.size()),  32'h0);

`ifdef DECRYPT_RX_PARITY_EN
        send_frame(8'h09, 1'b1, 1'b1);
        exp_ferr++;
        chk("parity_err_count", 32'(ferr_cnt), 32'(exp_ferr));
        exp_q.push_back(8'h09);
        send_frame(8'h09, 1'b1, 1'b0);
        chk("parity_ok_drained", 32'(exp_q.size()), 32'h0);
`endif

        for (int i = 0; i < 400 && exp_q.size() != 0; i++) wait_cyc(1);
        chk("final_drain", 32'(exp_q.size()), 32'h0);
        chk("final_ferr",  32'(ferr_cnt),     32'(exp_ferr));
        chk("final_ovr",   32'(ovr_cnt),      32'(exp_ovr));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
